lsu: RTL and testbench

Load/store unit between the execute stage and the byte-addressed data RAM of the single-issue RV32 core. It:
- accepts one memory request at a time through a valid/ready handshake;
- forms the effective address and checks alignment and funct3 legality;
- drives the RAM strobes for exactly one cycle;
- returns load results or store completion to writeback as single-cycle pulses.

---
 rtl/lsu.sv | 212 +++++++++++++++++++++
 tb/tb_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one request at a time, EA/legality check, one-cycle RAM strobe, pulsed writeback.
// Optional LSU_RDATA_REG_EN inserts a CAPT state that registers mem_rdata before load writeback.
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_load,
    output logic              mem_store,
    output logic [2:0]        mem_access,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              done,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [ADDR_W-1:0] fault_addr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MEM   = 3'd1,
        RESP  = 3'd2,
        FAULT = 3'd3,
        CAPT  = 3'd4
    } state_e;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

    state_e            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [4:0]        rd_q, rd_d;
    logic              mem_load_q, mem_load_d;
    logic              mem_store_q, mem_store_d;
    logic [2:0]        mem_access_q, mem_access_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_cause_q, fault_cause_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    logic [ADDR_W-1:0] ea;
    logic              accept;
    logic              illegal;
    logic              misaligned;

    assign req_ready = (state_q == IDLE) && !rst;

    always_comb begin
        ea      = req_base + req_offset;
        accept  = req_valid && req_ready;
        illegal = (req_load == req_store)
               || (req_load  && (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111))
               || (req_store && (req_funct3 > 3'b010));
        misaligned = ((req_funct3[1:0] == 2'b01) && ea[0])
                  || ((req_funct3 == 3'b010) && (ea[1:0] != 2'b00));
    end

    always_comb begin
        state_d       = state_q;
        is_load_d     = is_load_q;
        rd_d          = rd_q;
        mem_load_d    = 1'b0;
        mem_store_d   = 1'b0;
        mem_access_d  = mem_access_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        done_d        = 1'b0;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || misaligned) begin
                        // illegal outranks misaligned when both apply
                        state_d       = FAULT;
                        done_d        = 1'b1;
                        fault_d       = 1'b1;
                        fault_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        fault_addr_d  = ea;
                    end else begin
                        state_d      = MEM;
                        is_load_d    = req_load;
                        rd_d         = req_rd;
                        mem_load_d   = req_load;
                        mem_store_d  = req_store;
                        mem_access_d = req_funct3;
                        mem_addr_d   = ea;
                        mem_wdata_d  = req_wdata;
                    end
                end
            end
            MEM: begin
`ifdef LSU_RDATA_REG_EN
                if (is_load_q) begin
                    state_d = CAPT;
                end else begin
                    state_d = RESP;
                    done_d  = 1'b1;
                end
`else
                state_d = RESP;
                done_d  = 1'b1;
                if (is_load_q) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                end
`endif
            end
            CAPT: begin
                // RAM data is valid this cycle; register it for the RESP pulse
                state_d    = RESP;
                done_d     = 1'b1;
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = mem_rdata;
            end
            RESP: begin
                state_d = IDLE;
`ifndef LSU_RDATA_REG_EN
                // keep the last load result so wb_data holds after the pulse
                if (is_load_q) begin
                    wb_data_d = mem_rdata;
                end
`endif
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            is_load_q     <= 1'b0;
            rd_q          <= 5'd0;
            mem_load_q    <= 1'b0;
            mem_store_q   <= 1'b0;
            mem_access_q  <= 3'd0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 32'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'd0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'd0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            is_load_q     <= is_load_d;
            rd_q          <= rd_d;
            mem_load_q    <= mem_load_d;
            mem_store_q   <= mem_store_d;
            mem_access_q  <= mem_access_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign mem_load    = mem_load_q;
    assign mem_store   = mem_store_q;
    assign mem_access  = mem_access_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign fault_addr  = fault_addr_q;

`ifdef LSU_RDATA_REG_EN
    assign wb_data = wb_data_q;
`else
    assign wb_data = (state_q == RESP && is_load_q) ? mem_rdata : wb_data_q;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small registered-read RAM model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_load, mem_store;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done, fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;

    int checks = 0;
    int fails  = 0;

`ifdef LSU_RDATA_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_load(mem_load), .mem_store(mem_store), .mem_access(mem_access),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    // RAM: registered read, byte-lane writes
    logic [31:0] ram [0:63];
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk) begin
        if (mem_store) begin
            case (mem_access)
                3'b000:  ram[mem_addr[7:2]][8*mem_addr[1:0] +: 8]   <= mem_wdata[7:0];
                3'b001:  ram[mem_addr[7:2]][16*mem_addr[1] +: 16]   <= mem_wdata[15:0];
                default: ram[mem_addr[7:2]]                         <= mem_wdata;
            endcase
        end
        if (mem_load) mem_rdata <= ram[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a request, waits for acceptance; returns at the negedge of the cycle after accept.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd);
        int waited = 0;
        @(negedge clk);
        req_load = ld; req_store = st; req_funct3 = f3;
        req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        while (!req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_outs", {mem_load, mem_store, wb_valid, done, fault, fault_cause, mem_access}, 32'd0);
        chk("rst_addr", mem_addr | fault_addr | mem_wdata | wb_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);

        // store word 0x100+4
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'd4, 32'hDEADBEEF, 5'd3);
        chk("st_strobe", {mem_store, mem_load}, 32'b10);
        chk("st_addr", mem_addr, 32'h104);
        chk("st_access", 32'(mem_access), 32'd2);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("st_done", 32'(done), 32'd1);
        chk("st_wbv", 32'(wb_valid), 32'd0);
        chk("st_strobe_off", {mem_store, mem_load}, 32'd0);
        chk("st_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("st_done_off", 32'(done), 32'd0);
        chk("st_ready_back", 32'(req_ready), 32'd1);

        // load word back
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 5'd7);
        chk("ld_strobe", {mem_load, mem_store}, 32'b10);
        chk("ld_addr", mem_addr, 32'h104);
        for (int i = 2; i < LAT; i++) begin
            @(negedge clk);
            chk("ld_early", {wb_valid, done}, 32'd0);
        end
        @(negedge clk);
        chk("ld_wbv", 32'(wb_valid), 32'd1);
        chk("ld_data", wb_data, 32'hDEADBEEF);
        chk("ld_rd", 32'(wb_rd), 32'd7);
        chk("ld_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("ld_wbv_off", 32'(wb_valid), 32'd0);
        chk("ld_data_hold", wb_data, 32'hDEADBEEF);

        // misaligned halfword at 0x103
        issue(1'b1, 1'b0, 3'b001, 32'h100, 32'd3, 32'd0, 5'd1);
        chk("mis_fault", {fault, done}, 32'b11);
        chk("mis_cause", 32'(fault_cause), 32'd1);
        chk("mis_addr", fault_addr, 32'h103);
        chk("mis_nostrobe", {mem_load, mem_store}, 32'd0);
        @(negedge clk);
        chk("mis_off", {fault, done, mem_load}, 32'd0);
        chk("mis_addr_hold", fault_addr, 32'h103);
        chk("mis_ready", 32'(req_ready), 32'd1);

        // illegal load funct3 011
        issue(1'b1, 1'b0, 3'b011, 32'h200, 32'd0, 32'd0, 5'd1);
        chk("ill_f3", {fault, done, fault_cause, mem_load, mem_store}, 32'b111000);

        // load and store both set
        issue(1'b1, 1'b1, 3'b010, 32'h200, 32'd0, 32'd0, 5'd1);
        chk("ill_both", {fault, done, fault_cause, mem_load, mem_store}, 32'b111000);

        // store halfword-class funct3 101 at odd address: illegal wins
        issue(1'b0, 1'b1, 3'b101, 32'h200, 32'd1, 32'd0, 5'd1);
        chk("ill_mis", {fault, done, fault_cause, mem_load, mem_store}, 32'b111000);
        chk("ill_mis_addr", fault_addr, 32'h201);
        chk("ill_mis_mem_hold", mem_addr, 32'h104);

        // address wrap
        issue(1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'd8, 32'h12345678, 5'd0);
        chk("wrap_addr", mem_addr, 32'h4);
        chk("wrap_strobe", {mem_store, fault}, 32'b10);
        @(negedge clk);
        chk("wrap_done", {done, fault}, 32'b10);
        @(negedge clk);

        // byte unsigned load at odd address is legal
        issue(1'b1, 1'b0, 3'b100, 32'h100, 32'd5, 32'd0, 5'd2);
        chk("lbu_strobe", {mem_load, fault}, 32'b10);
        chk("lbu_access", 32'(mem_access), 32'd4);
        repeat (LAT) @(negedge clk);
        chk("lbu_idle", 32'(req_ready), 32'd1);

        // back-to-back stores with req_valid held
        req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
        req_base = 32'h300; req_offset = 32'd0; req_wdata = 32'hA5A5A5A5;
        req_valid = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 9; i++) begin
            chk("b2b_ready", 32'(req_ready), 32'((i % 3) == 0));
            if (done) dcnt++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_dones", 32'(dcnt), 32'd3);

        // reset during MEM of a load
        issue(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'd0, 5'd9);
        chk("rstm_strobe", 32'(mem_load), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_outs", {wb_valid, done, fault, mem_load, mem_store, req_ready}, 32'd0);
        chk("rstm_regs", mem_addr | 32'(wb_rd) | wb_data | 32'(mem_access), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstm_ready", 32'(req_ready), 32'd1);
        chk("rstm_nowb", {wb_valid, done, mem_load}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
